// File: rtl/seq_miter_pkg.sv
// seq_miter_pkg: shared FSM state type, warm-up counter width and first_ch width helper
package seq_miter_pkg;

    typedef enum logic [1:0] {
        WARMUP  = 2'd0,
        COMPARE = 2'd1,
        FAILED  = 2'd2
    } state_e;

    // LAT_DIFF is at most 15, so a 4-bit warm-up down-counter is enough
    localparam int LAT_W = 4;

    // first_ch width: at least one bit even for a single channel
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_miter_delay.sv
// seq_miter_delay: DEPTH-stage valid/data shift register (DEPTH=0 is a wire-through)
// Ports: clk, rst_n (async, active-low), clear (sync restart),
//        i_valid/i_data in, o_valid/o_data out after DEPTH clocks.
// Only the valid bits are reset or cleared; data is don't-care while valid is 0.
module seq_miter_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = ^{clk, rst_n, clear};
        assign o_valid  = i_valid;
        assign o_data   = i_data;
    end else begin : g_reg
        logic [DEPTH-1:0] r_v;
        logic [WIDTH-1:0] r_d [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= '0;
            end else if (clear) begin
                r_v <= '0;
            end else begin
                r_v[0] <= i_valid;
                for (int k = 1; k < DEPTH; k++) r_v[k] <= r_v[k-1];
            end
        end
        always_ff @(posedge clk) begin
            r_d[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) r_d[k] <= r_d[k-1];
        end
        assign o_valid = r_v[DEPTH-1];
        assign o_data  = r_d[DEPTH-1];
    end

endmodule

// File: rtl/seq_miter.sv
// seq_miter: sequential miter comparing CHANNELS spec/impl valid-data streams, impl lagging by LAT_DIFF
// Ports: clk, rst_n (async, active-low), clear (sync session restart),
//        spec_valid/spec_data, impl_valid/impl_data (channel i at [i*WIDTH +: WIDTH]),
//        warm (comparing), mismatch (sticky), first_ch (lowest failing channel of first
//        failing cycle), mismatch_cnt / compare_cnt (saturating cycle counts).
// Build option: define SEQ_MITER_ASSERT_EN to embed the no_mismatch assertion and the
//        warm_reached / compared covers; outputs are identical either way.
module seq_miter
    import seq_miter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int LAT_DIFF = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       spec_valid,
    input  logic [CHANNELS*WIDTH-1:0] spec_data,
    input  logic [CHANNELS-1:0]       impl_valid,
    input  logic [CHANNELS*WIDTH-1:0] impl_data,
    output logic                      warm,
    output logic                      mismatch,
    output logic [ch_w(CHANNELS)-1:0] first_ch,
    output logic [CNT_W-1:0]          mismatch_cnt,
    output logic [CNT_W-1:0]          compare_cnt
);

    localparam int CH_W = ch_w(CHANNELS);

    state_e                    r_state, w_state_nxt;
    logic [LAT_W-1:0]          r_cnt, w_cnt_nxt;
    logic                      r_mis;
    logic [CH_W-1:0]           r_first, w_low;
    logic [CNT_W-1:0]          r_mcnt, r_ccnt;
    logic [CHANNELS-1:0]       w_dv, w_fail, w_both;
    logic [CHANNELS*WIDTH-1:0] w_dd;
    logic                      w_active, w_any_fail, w_any_both;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        seq_miter_delay #(.WIDTH(WIDTH), .DEPTH(LAT_DIFF)) u_dly (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .i_valid (spec_valid[c]),
            .i_data  (spec_data[c*WIDTH +: WIDTH]),
            .o_valid (w_dv[c]),
            .o_data  (w_dd[c*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        w_fail = '0;
        w_both = '0;
        w_low  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_both[i] = w_dv[i] & impl_valid[i];
            w_fail[i] = (w_dv[i] != impl_valid[i]) ||
                        (w_both[i] && (w_dd[i*WIDTH +: WIDTH] != impl_data[i*WIDTH +: WIDTH]));
        end
        // descending scan so the lowest failing index wins
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_fail[i]) w_low = CH_W'(i);
        end
    end

    assign w_active   = (r_state != WARMUP);
    assign w_any_fail = |w_fail;
    assign w_any_both = |w_both;

    // counter value 1 (or 0 for LAT_DIFF=0) is the last warm-up cycle, so COMPARE
    // is entered LAT_DIFF edges after reset, or one edge when LAT_DIFF=0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WARMUP: begin
                w_cnt_nxt = (r_cnt == '0) ? r_cnt : r_cnt - LAT_W'(1);
                if (r_cnt <= LAT_W'(1)) w_state_nxt = COMPARE;
            end
            COMPARE: if (w_any_fail) w_state_nxt = FAILED;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WARMUP;
            r_cnt   <= LAT_W'(LAT_DIFF);
            r_mis   <= 1'b0;
            r_first <= '0;
            r_mcnt  <= '0;
            r_ccnt  <= '0;
        end else if (clear) begin
            r_state <= WARMUP;
            r_cnt   <= LAT_W'(LAT_DIFF);
            r_mis   <= 1'b0;
            r_first <= '0;
            r_mcnt  <= '0;
            r_ccnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_active && w_any_fail) r_mis <= 1'b1;
            if (r_state == COMPARE && w_any_fail) r_first <= w_low;
            if (w_active && w_any_fail && !(&r_mcnt)) r_mcnt <= r_mcnt + CNT_W'(1);
            if (w_active && w_any_both && !(&r_ccnt)) r_ccnt <= r_ccnt + CNT_W'(1);
        end
    end

    assign warm         = w_active;
    assign mismatch     = r_mis;
    assign first_ch     = r_first;
    assign mismatch_cnt = r_mcnt;
    assign compare_cnt  = r_ccnt;

`ifdef SEQ_MITER_ASSERT_EN
    default clocking cb @(posedge clk);
    endclocking

    no_mismatch: assert property (disable iff (!rst_n || clear) w_active |-> !w_any_fail);
    warm_reached: cover property ($rose(warm));
    compared: cover property (compare_cnt != '0);
`else
`endif

endmodule

// File: tb/tb_seq_miter.sv
// tb_seq_miter: randomized self-checking bench for seq_miter against a history-based reference model
// Instances: u0 (defaults, LAT_DIFF=2), u1 (CNT_W=2), u2 (LAT_DIFF=0); u0/u1 see impl = spec two
// cycles late, u2 sees impl = spec in the same cycle; all share clk, rst_n, clear and spec.
module tb_seq_miter;

    logic        clk, rst_n, clear;
    logic [1:0]  sv, iv, iv0;
    logic [15:0] sd, id, id0;
    logic        o_warm [3];
    logic        o_mis [3];
    logic [0:0]  o_first [3];
    logic [15:0] o_mcnt [3];
    logic [15:0] o_ccnt [3];
    logic [1:0]  w1_mcnt, w1_ccnt;

    int n_pass = 0, n_total = 0;

    // model state: per-instance session edge count and spec history ring
    int          mn [3];
    logic [1:0]  hv [3][16];
    logic [15:0] hd [3][16];
    logic        m_warm [3];
    logic        m_mis [3];
    logic [0:0]  m_first [3];
    logic [15:0] m_mcnt [3];
    logic [15:0] m_ccnt [3];

    // stimulus history used to build the lagging impl stream
    logic [1:0]  p1v = '0, p2v = '0;
    logic [15:0] p1d = '0, p2d = '0;

    seq_miter u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .spec_valid(sv), .spec_data(sd), .impl_valid(iv), .impl_data(id),
        .warm(o_warm[0]), .mismatch(o_mis[0]), .first_ch(o_first[0]),
        .mismatch_cnt(o_mcnt[0]), .compare_cnt(o_ccnt[0])
    );

    seq_miter #(.CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .spec_valid(sv), .spec_data(sd), .impl_valid(iv), .impl_data(id),
        .warm(o_warm[1]), .mismatch(o_mis[1]), .first_ch(o_first[1]),
        .mismatch_cnt(w1_mcnt), .compare_cnt(w1_ccnt)
    );
    assign o_mcnt[1] = {14'b0, w1_mcnt};
    assign o_ccnt[1] = {14'b0, w1_ccnt};

    seq_miter #(.LAT_DIFF(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .spec_valid(sv), .spec_data(sd), .impl_valid(iv0), .impl_data(id0),
        .warm(o_warm[2]), .mismatch(o_mis[2]), .first_ch(o_first[2]),
        .mismatch_cnt(o_mcnt[2]), .compare_cnt(o_ccnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mn[k] = 0; m_warm[k] = 0; m_mis[k] = 0; m_first[k] = '0; m_mcnt[k] = '0; m_ccnt[k] = '0;
        end
    endtask

    // What each miter must report after the coming edge: compare the impl sample with the
    // spec sample LAT edges back in the same session, once warm-up (max(LAT,1) edges) is over.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int l, w, low;
            logic [1:0] dv, ik;
            logic [15:0] dd, dk, cap;
            logic af, ab;
            l = (k == 2) ? 0 : 2;
            w = (l > 1) ? l : 1;
            cap = (k == 1) ? 16'd3 : 16'hFFFF;
            if (clear) begin
                mn[k] = 0; m_warm[k] = 0; m_mis[k] = 0; m_first[k] = '0; m_mcnt[k] = '0; m_ccnt[k] = '0;
            end else begin
                mn[k]++;
                hv[k][mn[k] % 16] = sv;
                hd[k][mn[k] % 16] = sd;
                if (mn[k] > w) begin
                    dv = hv[k][(mn[k] - l) % 16];
                    dd = hd[k][(mn[k] - l) % 16];
                    ik = (k == 2) ? iv0 : iv;
                    dk = (k == 2) ? id0 : id;
                    af = 0; ab = 0; low = 0;
                    for (int c = 1; c >= 0; c--) begin
                        if (dv[c] && ik[c]) ab = 1;
                        if (dv[c] != ik[c] || (dv[c] && dd[c*8 +: 8] != dk[c*8 +: 8])) begin
                            af = 1; low = c;
                        end
                    end
                    if (af) begin
                        if (!m_mis[k]) m_first[k] = 1'(low);
                        m_mis[k] = 1;
                        if (m_mcnt[k] < cap) m_mcnt[k]++;
                    end
                    if (ab && m_ccnt[k] < cap) m_ccnt[k]++;
                end
                m_warm[k] = (mn[k] >= w);
            end
        end
    endtask

    // One clock: spec random or forced, impl derived from spec history with xor faults.
    task automatic step(input bit rnd, input logic [1:0] fv, input logic [15:0] fd,
                        input logic [1:0] xv, input logic [15:0] xd);
        sv  = rnd ? 2'($urandom_range(0, 3)) : fv;
        sd  = rnd ? 16'($urandom) : fd;
        iv  = p2v ^ xv;
        id  = p2d ^ xd;
        iv0 = sv ^ xv;
        id0 = sd ^ xd;
        p2v = p1v; p2d = p1d; p1v = sv; p1d = sd;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1, 0, 0, 0, 0);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0;
        sv = '0; sd = '0; iv = '0; id = '0; iv0 = '0; id0 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (o_warm[k] !== 0 || o_mis[k] !== 0 || o_first[k] !== 0 || o_mcnt[k] !== 0 || o_ccnt[k] !== 0)
                $display("FAIL reset u%0d: warm=%b mis=%b first=%0d mcnt=%0d ccnt=%0d, all required 0",
                         k, o_warm[k], o_mis[k], o_first[k], o_mcnt[k], o_ccnt[k]);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_match();
        for (int t = 1; t <= 50; t++) begin
            step(1, 0, 0, 0, 0);
            if (t <= 3) begin
                n_total++;
                if (o_warm[0] !== (t >= 2)) $display("FAIL warm_edge t=%0d: warm=%b required %b", t, o_warm[0], t >= 2);
                else n_pass++;
            end
            for (int k = 0; k < 3; k++) begin
                n_total++;
                if (o_warm[k] !== m_warm[k] || o_mis[k] !== m_mis[k] || o_first[k] !== m_first[k] ||
                    o_mcnt[k] !== m_mcnt[k] || o_ccnt[k] !== m_ccnt[k])
                    $display("FAIL match u%0d t=%0d: got w=%b m=%b f=%0d mc=%0d cc=%0d required w=%b m=%b f=%0d mc=%0d cc=%0d",
                             k, t, o_warm[k], o_mis[k], o_first[k], o_mcnt[k], o_ccnt[k],
                             m_warm[k], m_mis[k], m_first[k], m_mcnt[k], m_ccnt[k]);
                else n_pass++;
            end
        end
        n_total++;
        if (o_mis[0] !== 0 || o_mcnt[0] !== 0 || o_ccnt[0] == 0)
            $display("FAIL match_end: mis=%b mcnt=%0d ccnt=%0d required 0,0,nonzero", o_mis[0], o_mcnt[0], o_ccnt[0]);
        else n_pass++;
    endtask

    task automatic test_first_fail();
        step(0, 2'b11, 16'hA53C, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 16'hFF00);
        n_total++;
        if (o_mis[0] !== 1 || o_first[0] !== 1 || o_mcnt[0] !== 1 || o_warm[0] !== 1)
            $display("FAIL first_ch1: mis=%b first=%0d mcnt=%0d warm=%b required 1,1,1,1",
                     o_mis[0], o_first[0], o_mcnt[0], o_warm[0]);
        else n_pass++;
        do_clear();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 2'b11, 16'h1234, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 16'hFFFF);
        n_total++;
        if (o_mis[0] !== 1 || o_first[0] !== 0 || o_mcnt[0] !== 1)
            $display("FAIL both_ch: mis=%b first=%0d mcnt=%0d required 1,0,1", o_mis[0], o_first[0], o_mcnt[0]);
        else n_pass++;
        step(0, 2'b10, 16'h7700, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 16'hFF00);
        n_total++;
        if (o_first[0] !== 0 || o_mcnt[0] !== 2)
            $display("FAIL later_ch1: first=%0d mcnt=%0d required 0,2", o_first[0], o_mcnt[0]);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (o_mis[k] !== m_mis[k] || o_first[k] !== m_first[k] || o_mcnt[k] !== m_mcnt[k] || o_ccnt[k] !== m_ccnt[k])
                $display("FAIL first_model u%0d: got m=%b f=%0d mc=%0d cc=%0d required m=%b f=%0d mc=%0d cc=%0d",
                         k, o_mis[k], o_first[k], o_mcnt[k], o_ccnt[k], m_mis[k], m_first[k], m_mcnt[k], m_ccnt[k]);
            else n_pass++;
        end
    endtask

    task automatic test_valid_only();
        do_clear();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 2'b10, 16'h4200, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 2'b01, 0);
        n_total++;
        if (o_mis[0] !== 1 || o_first[0] !== 0 || o_mcnt[0] !== 1)
            $display("FAIL valid_only: mis=%b first=%0d mcnt=%0d required 1,0,1", o_mis[0], o_first[0], o_mcnt[0]);
        else n_pass++;
        n_total++;
        if (o_mis[0] !== m_mis[0] || o_ccnt[0] !== m_ccnt[0])
            $display("FAIL valid_only_model: mis=%b ccnt=%0d required %b,%0d", o_mis[0], o_ccnt[0], m_mis[0], m_ccnt[0]);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_clear();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 0, 2'b11, 0);
        step(0, 2'b00, 0, 2'b11, 0);
        step(1, 0, 0, 2'b11, 0);
        step(1, 0, 0, 2'b11, 0);
        n_total++;
        if (o_mcnt[1] !== 3 || o_mcnt[0] !== 4 || o_mcnt[1] !== m_mcnt[1])
            $display("FAIL saturate: u1 mcnt=%0d u0 mcnt=%0d required 3,4", o_mcnt[1], o_mcnt[0]);
        else n_pass++;
        do_clear();
        n_total++;
        if (o_warm[1] !== 0 || o_mis[1] !== 0 || o_first[1] !== 0 || o_mcnt[1] !== 0 || o_ccnt[1] !== 0)
            $display("FAIL clear: warm=%b mis=%b first=%0d mcnt=%0d ccnt=%0d required all 0",
                     o_warm[1], o_mis[1], o_first[1], o_mcnt[1], o_ccnt[1]);
        else n_pass++;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (o_warm[1] !== 0) $display("FAIL clear_warm1: warm=%b required 0", o_warm[1]);
        else n_pass++;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (o_warm[1] !== 1) $display("FAIL clear_warm2: warm=%b required 1", o_warm[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(0, 2'b11, 16'h0F0F, 0, 16'hFFFF);
        step(0, 2'b11, 16'h1111, 0, 16'hFFFF);
        n_total++;
        if (o_mis[2] !== 1 || o_warm[2] !== 1 || o_mis[2] !== m_mis[2])
            $display("FAIL lat0_fail: mis=%b warm=%b required 1,1", o_mis[2], o_warm[2]);
        else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (o_warm[k] !== 0 || o_mis[k] !== 0 || o_first[k] !== 0 || o_mcnt[k] !== 0 || o_ccnt[k] !== 0)
                $display("FAIL async_reset u%0d: warm=%b mis=%b first=%0d mcnt=%0d ccnt=%0d, all required 0",
                         k, o_warm[k], o_mis[k], o_first[k], o_mcnt[k], o_ccnt[k]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0);
        n_total++;
        if (o_warm[2] !== 1 || o_warm[0] !== 0)
            $display("FAIL lat0_warm: u2 warm=%b u0 warm=%b required 1,0", o_warm[2], o_warm[0]);
        else n_pass++;
        for (int t = 0; t < 6; t++) begin
            step(1, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                n_total++;
                if (o_warm[k] !== m_warm[k] || o_mis[k] !== m_mis[k] || o_mcnt[k] !== m_mcnt[k] || o_ccnt[k] !== m_ccnt[k])
                    $display("FAIL post_reset u%0d t=%0d: got w=%b m=%b mc=%0d cc=%0d required w=%b m=%b mc=%0d cc=%0d",
                             k, t, o_warm[k], o_mis[k], o_mcnt[k], o_ccnt[k], m_warm[k], m_mis[k], m_mcnt[k], m_ccnt[k]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_first_fail();
        test_valid_only();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
